// File: rtl/proc_pkg.sv
// Shared constants for the multicycle processor: opcodes, time steps, bus selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Bus-select vector is one-hot: bits [7:0] pick R0..R7, SEL_G picks G,
// SEL_DIN picks the external DIN word. All-zero drives 0x0000 onto the bus.
package proc_pkg;

   localparam int DATA_W = 16;
   localparam int IR_W   = 9;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;
   localparam logic [2:0] OP_AND  = 3'b101;

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   localparam int SEL_W   = 10;
   localparam int SEL_G   = 8;
   localparam int SEL_DIN = 9;

   // One-hot bus select for general register r.
   function automatic logic [SEL_W-1:0] sel_reg(input logic [2:0] r);
      logic [SEL_W-1:0] s;
      s    = '0;
      s[r] = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/regn.sv
// Datapath register: captures D on the falling clock edge when en is high.
// Latency: one falling edge from en/D to Q.
// Backpressure: none; en simply holds the value.
//
// Ports: clk (captures on negedge), clr (async active-high clear), en, D, Q.
module regn #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] D,
   output logic [W-1:0] Q
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   always_comb begin
      q_d = en ? D : q_q;
   end

   always_ff @(negedge clk or posedge clr) begin
      if (clr) q_q <= '0;
      else     q_q <= q_d;
   end

   assign Q = q_q;

endmodule

// File: rtl/processador_multiciclo.sv
// Multicycle 16-bit processor: R0..R7, A, G, IR around one shared bus.
// Latency: 2 steps (mv/mvi/mvnz/no-op) or 4 steps (add/sub) including fetch in T0.
// Backpressure: none; a new instruction is accepted only in T0 when Run is high.
//
// Ports: Clock, Resetn (async, active-high clear despite the name), DIN (instruction
// in T0, immediate in T1 of mvi), Run, Done, BusWires, Rx_data/Ry_data (IR-addressed regs).
// Build option: define PROC_AND_EN to make opcode 101 a bitwise and (otherwise a no-op).
// Tstep advances on posedge; datapath registers capture on negedge, so control decoded
// from Tstep/IR is settled half a cycle before the registers sample the bus.
module processador_multiciclo
   import proc_pkg::*;
(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [DATA_W-1:0] DIN,
   input  logic              Run,
   output logic              Done,
   output logic [DATA_W-1:0] BusWires,
   output logic [DATA_W-1:0] Rx_data,
   output logic [DATA_W-1:0] Ry_data
);

   logic [1:0]        tstep_d, tstep_q;
   logic [IR_W-1:0]   ir_q;
   logic [DATA_W-1:0] r_q [8];
   logic [DATA_W-1:0] a_q, g_q, alu_res, bus;
   logic [SEL_W-1:0]  bus_sel;
   logic [7:0]        r_en;
   logic              ir_in, rx_in, a_in, g_in, done, is_arith;
   logic [2:0]        opcode, rx, ry;

   assign opcode = ir_q[8:6];
   assign rx     = ir_q[5:3];
   assign ry     = ir_q[2:0];

   always_comb begin
      is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
`ifdef PROC_AND_EN
      is_arith = is_arith || (opcode == OP_AND);
`endif
   end

   // Control unit: enables and bus select decoded from the current step and IR.
   always_comb begin
      ir_in   = 1'b0;
      rx_in   = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      done    = 1'b0;
      bus_sel = '0;
      case (tstep_q)
         T0: ir_in = Run;
         T1: begin
            if (is_arith) begin
               bus_sel = sel_reg(rx);
               a_in    = 1'b1;
            end else begin
               done = 1'b1;
               case (opcode)
                  OP_MV: begin
                     bus_sel = sel_reg(ry);
                     rx_in   = 1'b1;
                  end
                  OP_MVI: begin
                     bus_sel[SEL_DIN] = 1'b1;
                     rx_in            = 1'b1;
                  end
                  OP_MVNZ: begin
                     // Done completes the instruction even when the move is suppressed.
                     if (g_q != '0) begin
                        bus_sel = sel_reg(ry);
                        rx_in   = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         T2: begin
            if (is_arith) begin
               bus_sel = sel_reg(ry);
               g_in    = 1'b1;
            end else begin
               done = 1'b1;
            end
         end
         default: begin
            done = 1'b1;
            if (is_arith) begin
               bus_sel[SEL_G] = 1'b1;
               rx_in          = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      if (tstep_q == T0) tstep_d = Run ? T1 : T0;
      else if (done)     tstep_d = T0;
      else               tstep_d = tstep_q + 2'd1;
   end

   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn) tstep_q <= T0;
      else        tstep_q <= tstep_d;
   end

   always_comb begin
      r_en = rx_in ? (8'b1 << rx) : 8'b0;
   end

   // Selects are one-hot, so OR-ing the gated sources is a plain mux.
   always_comb begin
      bus = '0;
      for (int i = 0; i < 8; i++) begin
         if (bus_sel[i]) bus = bus | r_q[i];
      end
      if (bus_sel[SEL_G])   bus = bus | g_q;
      if (bus_sel[SEL_DIN]) bus = bus | DIN;
   end

   always_comb begin
      alu_res = a_q + bus;
      case (opcode)
         OP_SUB:  alu_res = a_q - bus;
`ifdef PROC_AND_EN
         OP_AND:  alu_res = a_q & bus;
`endif
         default: ;
      endcase
   end

   regn #(.W(DATA_W)) R0 (.clk(Clock), .clr(Resetn), .en(r_en[0]), .D(bus), .Q(r_q[0]));
   regn #(.W(DATA_W)) R1 (.clk(Clock), .clr(Resetn), .en(r_en[1]), .D(bus), .Q(r_q[1]));
   regn #(.W(DATA_W)) R2 (.clk(Clock), .clr(Resetn), .en(r_en[2]), .D(bus), .Q(r_q[2]));
   regn #(.W(DATA_W)) R3 (.clk(Clock), .clr(Resetn), .en(r_en[3]), .D(bus), .Q(r_q[3]));
   regn #(.W(DATA_W)) R4 (.clk(Clock), .clr(Resetn), .en(r_en[4]), .D(bus), .Q(r_q[4]));
   regn #(.W(DATA_W)) R5 (.clk(Clock), .clr(Resetn), .en(r_en[5]), .D(bus), .Q(r_q[5]));
   regn #(.W(DATA_W)) R6 (.clk(Clock), .clr(Resetn), .en(r_en[6]), .D(bus), .Q(r_q[6]));
   regn #(.W(DATA_W)) R7 (.clk(Clock), .clr(Resetn), .en(r_en[7]), .D(bus), .Q(r_q[7]));
   regn #(.W(DATA_W)) A  (.clk(Clock), .clr(Resetn), .en(a_in),    .D(bus), .Q(a_q));
   regn #(.W(DATA_W)) G  (.clk(Clock), .clr(Resetn), .en(g_in),    .D(alu_res), .Q(g_q));
   regn #(.W(IR_W))   IR (.clk(Clock), .clr(Resetn), .en(ir_in),   .D(DIN[IR_W-1:0]), .Q(ir_q));

   assign Done     = done;
   assign BusWires = bus;
   assign Rx_data  = r_q[rx];
   assign Ry_data  = r_q[ry];

endmodule

// File: tb/tb_processador_multiciclo.sv
module tb_processador_multiciclo;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic [15:0] DIN;
   logic        Run;
   logic        Done;
   logic [15:0] BusWires;
   logic [15:0] Rx_data;
   logic [15:0] Ry_data;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] exp_q[$];
   string       tag_q[$];

   processador_multiciclo dut (
      .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run),
      .Done(Done), .BusWires(BusWires), .Rx_data(Rx_data), .Ry_data(Ry_data)
   );

   always #5 Clock = ~Clock;

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic expect_v(input string tag, input logic [15:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic chk(input logic [15:0] obs);
      logic [15:0] e;
      string       t;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: observed %h expected <none>", obs);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
   endtask

   function automatic logic [15:0] ts();
      return {14'd0, dut.tstep_q};
   endfunction
   function automatic logic [15:0] dn();
      return {15'd0, Done};
   endfunction
   function automatic logic [15:0] irv();
      return {7'd0, dut.IR.Q};
   endfunction

   // Caller sits just after a posedge with Tstep=0; present instruction and Run.
   task automatic fetch(input logic [8:0] ir);
      DIN = {7'd0, ir};
      Run = 1'b1;
      @(negedge Clock); #1;
   endtask
   task automatic step;
      @(posedge Clock); #1;
      Run = 1'b0;
   endtask
   task automatic half;
      @(negedge Clock); #1;
   endtask
   task automatic load(input logic [2:0] r, input logic [15:0] v);
      fetch({3'b001, r, 3'b000});
      DIN = v;
      step; half; step;
   endtask
   task automatic arith(input logic [8:0] ir);
      fetch(ir);
      step; half; step; half; step; half; step;
   endtask

   initial begin
      Resetn = 1'b1; Run = 1'b0; DIN = 16'h0000;
      #12;
      expect_v("rst_tstep", 16'd0); expect_v("rst_done", 16'd0); expect_v("rst_bus", 16'd0);
      expect_v("rst_r0", 16'd0);    expect_v("rst_a", 16'd0);    expect_v("rst_g", 16'd0);
      expect_v("rst_ir", 16'd0);
      chk(ts()); chk(dn()); chk(BusWires); chk(dut.R0.Q); chk(dut.A.Q); chk(dut.G.Q); chk(irv());
      Resetn = 1'b0;
      step;

      // mv R0,R1 with R0=11, R1=10
      load(3'd0, 16'd11);
      load(3'd1, 16'd10);
      expect_v("mv_ir", 16'h0001);
      fetch(9'b000000001); chk(irv());
      expect_v("mv_tstep1", 16'd1); expect_v("mv_done", 16'd1); expect_v("mv_bus", 16'd10);
      step; chk(ts()); chk(dn()); chk(BusWires);
      expect_v("mv_r0", 16'd10);
      half; chk(dut.R0.Q);
      expect_v("mv_tstep0", 16'd0);
      step; chk(ts());

      // mvi R0 = 5
      fetch(9'b001000001);
      DIN = 16'd5;
      expect_v("mvi_bus", 16'd5); expect_v("mvi_done", 16'd1);
      step; chk(BusWires); chk(dn());
      expect_v("mvi_r0", 16'd5);
      half; chk(dut.R0.Q);
      step;

      // sub R1,R0 with R0=5, R1=10
      fetch(9'b011001000);
      expect_v("sub_t1_done", 16'd0); expect_v("sub_t1_bus", 16'd10);
      step; chk(dn()); chk(BusWires);
      expect_v("sub_a", 16'd10);
      half; chk(dut.A.Q);
      expect_v("sub_t2_done", 16'd0); expect_v("sub_t2_step", 16'd2); expect_v("sub_t2_bus", 16'd5);
      step; chk(dn()); chk(ts()); chk(BusWires);
      expect_v("sub_g", 16'd5);
      half; chk(dut.G.Q);
      expect_v("sub_t3_done", 16'd1); expect_v("sub_t3_step", 16'd3); expect_v("sub_t3_bus", 16'd5);
      step; chk(dn()); chk(ts()); chk(BusWires);
      expect_v("sub_r1", 16'd5);
      half; chk(dut.R1.Q);
      expect_v("sub_end_step", 16'd0);
      step; chk(ts());

      // add R1,R0: 5+5
      expect_v("add_r1", 16'd10);
      arith(9'b010001000); chk(dut.R1.Q);
      // sub R0,R1: 5-10 wraps
      expect_v("sub_wrap_r0", 16'd65531);
      arith(9'b011000001); chk(dut.R0.Q);
      // sub R1,R1 gives zero, G becomes 0
      expect_v("sub_self_r1", 16'd0); expect_v("sub_self_g", 16'd0);
      arith(9'b011001001); chk(dut.R1.Q); chk(dut.G.Q);

      // mvnz R0,R1 with G=0: no move
      load(3'd0, 16'd11);
      load(3'd1, 16'd10);
      expect_v("mvnz0_rx_data", 16'd11); expect_v("mvnz0_ry_data", 16'd10);
      fetch(9'b100000001); chk(Rx_data); chk(Ry_data);
      expect_v("mvnz0_done", 16'd1); expect_v("mvnz0_bus", 16'd0);
      step; chk(dn()); chk(BusWires);
      expect_v("mvnz0_r0", 16'd11);
      half; chk(dut.R0.Q);
      step;

      // mvnz R0,R1 with G=5 (via R2=5 minus R3=0)
      load(3'd2, 16'd5);
      expect_v("g_five", 16'd5);
      arith(9'b011010011); chk(dut.G.Q);
      fetch(9'b100000001);
      expect_v("mvnz1_done", 16'd1); expect_v("mvnz1_bus", 16'd10);
      step; chk(dn()); chk(BusWires);
      expect_v("mvnz1_r0", 16'd10);
      half; chk(dut.R0.Q);
      step;

      // mv R0,R0 leaves R0 unchanged
      fetch(9'b000000000);
      step;
      expect_v("mv_self_r0", 16'd10);
      half; chk(dut.R0.Q);
      step;

      // opcode 110: no-op finishing in T1
      fetch(9'b110000001);
      expect_v("nop_done", 16'd1); expect_v("nop_bus", 16'd0);
      step; chk(dn()); chk(BusWires);
      expect_v("nop_r0", 16'd10);
      half; chk(dut.R0.Q);
      expect_v("nop_end_step", 16'd0);
      step; chk(ts());

      // opcode 101 on R1=10, R2=5
`ifdef PROC_AND_EN
      expect_v("and_r1", 16'd0);
      arith(9'b101001010); chk(dut.R1.Q);
`else
      fetch(9'b101001010);
      expect_v("op101_done", 16'd1);
      step; chk(dn());
      expect_v("op101_r1", 16'd10);
      half; chk(dut.R1.Q);
      step;
`endif

      // reset in the middle of sub (T2)
      fetch(9'b011001000);
      step; half; step;
      expect_v("midrst_pre_step", 16'd2);
      chk(ts());
      Resetn = 1'b1;
      #1;
      expect_v("midrst_step", 16'd0); expect_v("midrst_done", 16'd0); expect_v("midrst_bus", 16'd0);
      expect_v("midrst_r0", 16'd0);   expect_v("midrst_r1", 16'd0);   expect_v("midrst_a", 16'd0);
      expect_v("midrst_g", 16'd0);    expect_v("midrst_ir", 16'd0);
      chk(ts()); chk(dn()); chk(BusWires); chk(dut.R0.Q); chk(dut.R1.Q); chk(dut.A.Q);
      chk(dut.G.Q); chk(irv());
      half;
      Resetn = 1'b0;
      Run = 1'b0;
      DIN = 16'h01FF;
      expect_v("idle_step_a", 16'd0);
      step; chk(ts());
      expect_v("idle_ir", 16'd0);
      half; chk(irv());
      expect_v("idle_step_b", 16'd0);
      step; chk(ts());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
